// File: rtl/uart_param.sv
// Parametrised full-duplex UART with RX error flags and glitch-rejecting start.
// Optional UART_LOOPBACK_EN adds a loopback input routing TX into RX.
module uart_param #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 wr_en,
  output logic                 tx,
  output logic                 tx_busy,
  input  logic                 rx,
  output logic                 rdy,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] dout,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
`ifdef UART_LOOPBACK_EN
  ,
  input  logic                 loopback
`endif
);

  localparam int TX_DIV = CLK_HZ / BAUD;
  localparam int RX_DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int TXW = $clog2(TX_DIV + 1);
  localparam int RXW = $clog2(RX_DIV + 1);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic PODD = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } st_t;

  logic [TXW-1:0] r_txc;
  logic [RXW-1:0] r_rxc;
  logic           w_txt;
  logic           w_rxt;

  assign w_txt = (r_txc == TXW'(TX_DIV - 1));
  assign w_rxt = (r_rxc == RXW'(RX_DIV - 1));

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_txc <= '0;
      r_rxc <= '0;
    end else begin
      r_txc <= w_txt ? '0 : r_txc + TXW'(1);
      r_rxc <= w_rxt ? '0 : r_rxc + RXW'(1);
    end
  end

  st_t                  r_txst;
  logic                 r_tx;
  logic                 r_busy;
  logic [DATA_BITS-1:0] r_tsh;
  logic                 r_tpar;
  logic [BW-1:0]        r_tbit;
  logic                 r_tstop;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_txst  <= S_IDLE;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_tsh   <= '0;
      r_tpar  <= 1'b0;
      r_tbit  <= '0;
      r_tstop <= 1'b0;
    end else begin
      unique case (r_txst)
        S_IDLE: begin
          if (!r_busy) begin
            if (wr_en) begin
              r_tsh  <= din;
              r_tpar <= (^din) ^ PODD;
              r_busy <= 1'b1;
            end
          end else if (w_txt) begin
            r_txst <= S_START;
            r_tx   <= 1'b0;
          end
        end
        S_START: if (w_txt) begin
          r_txst <= S_DATA;
          r_tx   <= r_tsh[0];
          r_tsh  <= r_tsh >> 1;
          r_tbit <= '0;
        end
        S_DATA: if (w_txt) begin
          if (r_tbit == BW'(DATA_BITS - 1)) begin
            r_tstop <= 1'b0;
            if (PARITY != 0) begin
              r_txst <= S_PAR;
              r_tx   <= r_tpar;
            end else begin
              r_txst <= S_STOP;
              r_tx   <= 1'b1;
            end
          end else begin
            r_tx   <= r_tsh[0];
            r_tsh  <= r_tsh >> 1;
            r_tbit <= r_tbit + BW'(1);
          end
        end
        S_PAR: if (w_txt) begin
          r_txst <= S_STOP;
          r_tx   <= 1'b1;
        end
        S_STOP: if (w_txt) begin
          if (r_tstop == 1'(STOP_BITS - 1)) begin
            r_txst <= S_IDLE;
            r_busy <= 1'b0;
          end else begin
            r_tstop <= 1'b1;
          end
        end
        default: r_txst <= S_IDLE;
      endcase
    end
  end

  logic w_rxin;
`ifdef UART_LOOPBACK_EN
  assign w_rxin = loopback ? r_tx : rx;
  assign tx     = loopback ? 1'b1 : r_tx;
`else
  assign w_rxin = rx;
  assign tx     = r_tx;
`endif
  assign tx_busy = r_busy;

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= w_rxin;
      r_s2 <= r_s1;
    end
  end

  st_t                  r_rxst;
  logic [SW-1:0]        r_scnt;
  logic [BW-1:0]        r_rbit;
  logic [DATA_BITS-1:0] r_rsh;
  logic                 r_rpar;
  logic                 r_rdy;
  logic [DATA_BITS-1:0] r_dout;
  logic                 r_fe;
  logic                 r_pe;
  logic                 r_ovr;
  logic                 w_mid;

  assign w_mid = (r_scnt == SW'(OVERSAMPLE - 1));

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_rxst <= S_IDLE;
      r_scnt <= '0;
      r_rbit <= '0;
      r_rsh  <= '0;
      r_rpar <= 1'b0;
      r_rdy  <= 1'b0;
      r_dout <= '0;
      r_fe   <= 1'b0;
      r_pe   <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      if (rdy_clr) begin
        r_rdy <= 1'b0;
        r_ovr <= 1'b0;
      end
      // a completing word in the same cycle overrides the clear of rdy
      if (w_rxt) begin
        unique case (r_rxst)
          S_IDLE: if (!r_s2) begin
            r_rxst <= S_START;
            r_scnt <= '0;
          end
          S_START: begin
            if (r_scnt == SW'(OVERSAMPLE / 2 - 1)) begin
              r_scnt <= '0;
              r_rbit <= '0;
              r_rxst <= r_s2 ? S_IDLE : S_DATA;
            end else begin
              r_scnt <= r_scnt + SW'(1);
            end
          end
          S_DATA: begin
            if (w_mid) begin
              r_scnt <= '0;
              r_rsh  <= {r_s2, r_rsh[DATA_BITS-1:1]};
              r_rbit <= r_rbit + BW'(1);
              if (r_rbit == BW'(DATA_BITS - 1))
                r_rxst <= (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              r_scnt <= r_scnt + SW'(1);
            end
          end
          S_PAR: begin
            if (w_mid) begin
              r_scnt <= '0;
              r_rpar <= r_s2;
              r_rxst <= S_STOP;
            end else begin
              r_scnt <= r_scnt + SW'(1);
            end
          end
          S_STOP: begin
            if (w_mid) begin
              r_scnt <= '0;
              r_rxst <= S_IDLE;
              r_dout <= r_rsh;
              r_rdy  <= 1'b1;
              r_fe   <= !r_s2;
              r_pe   <= (PARITY != 0) && ((^r_rsh) ^ r_rpar ^ PODD);
              if (r_rdy && !rdy_clr) r_ovr <= 1'b1;
            end else begin
              r_scnt <= r_scnt + SW'(1);
            end
          end
          default: r_rxst <= S_IDLE;
        endcase
      end
    end
  end

  assign rdy        = r_rdy;
  assign dout       = r_dout;
  assign frame_err  = r_fe;
  assign parity_err = r_pe;
  assign overrun    = r_ovr;

endmodule

// File: doc/uart_param.md
Name: uart_param

Overview:
- Parametrised full-duplex UART: configurable data width, parity mode, stop-bit count, baud rate and RX oversampling.
- Adds RX error reporting (framing, parity, overrun), a glitch-rejecting start detector and an asynchronous active-low reset.
- Drop-in successor for the existing fixed 8N1 UART on the 50 MHz system clock; serves as the host serial link of the lab top level.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- DATA_BITS, 8, payload bits per frame, legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits transmitted, 1 or 2.
- OVERSAMPLE, 16, RX samples per bit period, even, at least 8.

Ports:
- clk_50m  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  DATA_BITS  TX payload, sampled when accepted.
- wr_en  in  1  TX write strobe.
- tx  out  1  serial TX line, idle high.
- tx_busy  out  1  transmitter occupied.
- rx  in  1  serial RX line, asynchronous.
- rdy  out  1  received word valid.
- rdy_clr  in  1  consumer acknowledge; clears rdy and overrun.
- dout  out  DATA_BITS  last received payload.
- frame_err  out  1  stop bit of the last word sampled low.
- parity_err  out  1  parity mismatch on the last word; always 0 when PARITY=0.
- overrun  out  1  sticky: a word completed while rdy was already 1.

Behaviour:
- Reset values: tx=1, tx_busy=0, rdy=0, dout=0, frame_err=0, parity_err=0, overrun=0. Reset clears both FSMs to IDLE and both dividers to 0, mid-frame included.
- Baud generation:
  - TX tick: one-cycle pulse every CLK_HZ/BAUD cycles (integer truncation).
  - RX tick: one-cycle pulse every CLK_HZ/(BAUD*OVERSAMPLE) cycles.
  - Both are free-running after reset.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
  - Accept: wr_en=1 with tx_busy=0 latches din; tx_busy is 1 from the next cycle.
  - wr_en while tx_busy=1 is ignored. No queueing.
  - START begins at the first TX tick after acceptance. Each bit is held for exactly one tick period.
  - Data is sent LSB first.
  - STOP drives 1 for STOP_BITS periods.
  - tx_busy falls in the cycle after the last stop period ends. A wr_en in that same cycle is accepted.
- RX input: rx passes through a 2-flop synchroniser reset to 1. All RX logic uses the synchronised value.
- RX FSM: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE. All states advance on RX ticks only.
  - IDLE: a low sample enters START and clears the sample counter.
  - START: at sample OVERSAMPLE/2, if the line is low, enter DATA; if high, treat it as a glitch and return to IDLE with no output change.
  - DATA and PARITY: each bit is sampled once, OVERSAMPLE ticks after the previous mid-bit sample. Bits are shifted LSB first.
  - STOP: only the first stop bit is sampled. In that same cycle:
    - dout is updated.
    - rdy is set to 1.
    - frame_err is set to (stop sample == 0).
    - parity_err is set to the parity mismatch.
  - Return to IDLE immediately after the stop sample. Extra stop bits are not required.
- Overrun: word completion while rdy=1 sets overrun=1. dout, frame_err and parity_err are overwritten with the new word.
- rdy_clr: clears rdy and overrun next cycle.
- Simultaneous rdy_clr and word completion: completion wins. rdy stays 1 and overrun is not set.
- frame_err and parity_err always describe the current dout. They are not cleared by rdy_clr.
- TX and RX are fully independent; concurrent activity is legal.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- Defined: adds input port loopback (1 bit).
  - When loopback=1, the RX synchroniser input is driven by the internal TX serial value instead of rx.
  - The tx pin is held at 1 while loopback=1.
  - Switching loopback mid-frame is allowed; the resulting frame is undefined but must recover by the next idle period.
- Undefined: no loopback port; RX always uses rx and tx always shows the TX serial value.

Test Plan:
- Defaults (434 clocks/bit), wr_en with din=8'hA5:
  - tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 434 cycles.
  - tx_busy high 4340 cycles, then low.
- Drive rx with a 0x3C frame at 115200:
  - rdy=1, dout=8'h3C, frame_err=0, parity_err=0.
  - rdy_clr -> rdy=0 next cycle.
- PARITY=2, rx frame 0x07 with parity bit 0 (wrong):
  - dout=8'h07, parity_err=1.
  - Next frame with correct parity -> parity_err=0.
- Two frames 0x11 then 0x22 with no rdy_clr:
  - overrun=1, dout=8'h22.
  - rdy_clr -> overrun=0, rdy=0.
- rx low pulse of 3 clocks with line otherwise idle -> no rdy, FSM back in IDLE. Frame with stop bit 0 -> frame_err=1.
- rst_n low mid TX frame -> tx=1, tx_busy=0 immediately. After release, wr_en 8'h5A sends a clean frame.
